fifo_rr_merge_arb: RTL

Round-robin arbiter that merges NREQ upstream FIFO2 queues into one downstream FIFO2. It connects directly to the upstream FIFO2 dequeue side (EMPTY_N/D_OUT/DEQ) and the downstream FIFO2 enqueue side (ENQ/D_IN/FULL_N). Grants are burst-locked: once a requester owns the output, it keeps it until its LAST beat or MAX_BURST beats. It sits in front of shared single-ported consumers, such as a bus master queue or a response merge point.

---
 rtl/fifo_rr_merge_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fifo_rr_merge_arb.sv
// Round-robin, burst-locked merge of NREQ upstream FIFO2 dequeue ports into one
// downstream FIFO2 enqueue port, with zero-latency data pass-through.
module fifo_rr_merge_arb #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned width     = 32,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         CLR,
   input  logic [NREQ-1:0]              src_EMPTY_N,
   input  logic [NREQ*width-1:0]        src_D_OUT,
   input  logic [NREQ-1:0]              src_LAST,
   output logic [NREQ-1:0]              src_DEQ,
   output logic [width-1:0]             dst_D_IN,
   output logic                         dst_ENQ,
   input  logic                         dst_FULL_N,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
   output logic                         busy
);

   localparam int unsigned GID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned PW    = GID_W + 1;
   localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state_q, state_d;
   logic [GID_W-1:0]   ptr_q, ptr_d;
   logic [GID_W-1:0]   grant_id_q, grant_id_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               owner_empty_n;
   logic               owner_last;
   logic               fire;
   logic               burst_end;
   logic [NREQ-1:0]    rot;
   logic               pick_found;
   logic [GID_W-1:0]   pick_idx;
   logic [PW-1:0]      pick_sum;
   logic [PW-1:0]      ptr_inc;

   // Owner view: head status and data of the current grant holder
   always_comb begin
      owner_empty_n = 1'b0;
      owner_last    = 1'b0;
      dst_D_IN      = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_id_q == GID_W'(i)) begin
            owner_empty_n = src_EMPTY_N[i];
            owner_last    = src_LAST[i];
            dst_D_IN      = src_D_OUT[i*width +: width];
         end
      end
   end

   assign fire      = owner_empty_n & dst_FULL_N;
   assign burst_end = owner_last | (cnt_q == CNT_W'(MAX_BURST - 1));

   // First non-empty requester at or after the pointer, searching upward mod NREQ
   assign rot = NREQ'({src_EMPTY_N, src_EMPTY_N} >> ptr_q);

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_sum   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!pick_found && rot[i]) begin
            pick_found = 1'b1;
            pick_sum   = PW'(ptr_q) + PW'(i);
            if (pick_sum >= PW'(NREQ)) pick_sum = pick_sum - PW'(NREQ);
            pick_idx   = GID_W'(pick_sum);
         end
      end
   end

   always_comb begin
      ptr_inc = PW'(grant_id_q) + PW'(1);
      if (ptr_inc == PW'(NREQ)) ptr_inc = '0;
   end

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         grant_id_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      cnt_d      = cnt_q;
      if (CLR) begin
         state_d    = IDLE;
         ptr_d      = '0;
         grant_id_d = '0;
         cnt_d      = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  grant_id_d = pick_idx;
                  cnt_d      = '0;
                  state_d    = GRANT;
               end
            end
            GRANT: begin
               if (fire) begin
                  if (burst_end) begin
                     state_d = IDLE;
                     ptr_d   = GID_W'(ptr_inc);
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs: strobes only in GRANT on a fire, suppressed by CLR
   always_comb begin
      busy    = (state_q == GRANT);
      dst_ENQ = busy & fire & ~CLR;
      src_DEQ = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         src_DEQ[i] = dst_ENQ & (grant_id_q == GID_W'(i));
      end
   end

   assign grant_id = grant_id_q;

endmodule
